// File: rtl/hello_scroller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hello_scroller_if : board-side control and display bundle for the scroller |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface hello_scroller_if #(
  parameter int N_DIGITS = 8
) ();
  logic                    load;
  logic [3*N_DIGITS-1:0]   load_data;
  logic [1:0]              mode;
  logic                    step;
  logic [3*N_DIGITS-1:0]   char_out;
  logic [7*N_DIGITS-1:0]   hex_out;
  logic                    tick;

  modport master (
    output load, load_data, mode, step,
    input  char_out, hex_out, tick
  );

  modport slave (
    input  load, load_data, mode, step,
    output char_out, hex_out, tick
  );
endinterface
`default_nettype wire

// File: rtl/hello_scroller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hello_scroller : rotating N-digit HELLO buffer with 7-segment decode       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hello_scroller #(
  parameter int N_DIGITS = 8,
  parameter int TICK_DIV = 50000000
) (
  input  logic             clk,
  input  logic             rst_n,
  hello_scroller_if.slave  bus
);
  localparam int              c_W         = 3 * N_DIGITS;
  localparam int              c_CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_CW-1:0] c_CNT_TOP   = c_CW'(TICK_DIV - 1);
  localparam logic [1:0]      c_MODE_LEFT   = 2'b01;
  localparam logic [1:0]      c_MODE_RIGHT  = 2'b10;
  localparam logic [1:0]      c_MODE_MANUAL = 2'b11;
  localparam logic [14:0]     c_HELLO     = {3'd0, 3'd1, 3'd2, 3'd2, 3'd3};
  localparam logic [2:0]      c_BLANK     = 3'd4;

  // HELLO is placed from the leftmost slot downward and truncated for short displays.
  function automatic logic [c_W-1:0] f_reset_buf();
    logic [c_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (k < 5) v[3*(N_DIGITS-1-k) +: 3] = c_HELLO[3*(4-k) +: 3];
      else       v[3*(N_DIGITS-1-k) +: 3] = c_BLANK;
    end
    return v;
  endfunction

  localparam logic [c_W-1:0] c_RESET_BUF = f_reset_buf();

  // Returned as {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] f_seg(input logic [2:0] code);
    logic [6:0] s;
    case (code)
      3'd0:    s = 7'b0001001;
      3'd1:    s = 7'b0000110;
      3'd2:    s = 7'b1000111;
      3'd3:    s = 7'b1000000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [c_W-1:0]  r_buf;
  logic [c_W-1:0]  w_buf_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] w_cnt_eff;
  logic [c_CW-1:0] w_cnt_nxt;
  logic [1:0]      r_mode_q;
  logic            r_step_q;
  logic            w_auto;
  logic            w_tick;
  logic            w_step_rise;
  logic            w_rot_left;
  logic            w_rot_right;

  always_comb begin
    w_auto      = (bus.mode == c_MODE_LEFT) || (bus.mode == c_MODE_RIGHT);
    // A fresh mode starts counting from zero in its very first cycle.
    w_cnt_eff   = (bus.mode != r_mode_q) ? '0 : r_cnt;
    w_tick      = w_auto && (w_cnt_eff == c_CNT_TOP);
    w_step_rise = bus.step & ~r_step_q;
    w_rot_left  = ((bus.mode == c_MODE_LEFT) && w_tick) ||
                  ((bus.mode == c_MODE_MANUAL) && w_step_rise);
    w_rot_right = (bus.mode == c_MODE_RIGHT) && w_tick;
  end

  always_comb begin
    w_buf_nxt = r_buf;
    if (bus.load)
      w_buf_nxt = bus.load_data;
    else if (w_rot_left)
      w_buf_nxt = {r_buf[c_W-4:0], r_buf[c_W-1 -: 3]};
    else if (w_rot_right)
      w_buf_nxt = {r_buf[2:0], r_buf[c_W-1:3]};

    w_cnt_nxt = '0;
    if (!bus.load && w_auto && !w_tick)
      w_cnt_nxt = w_cnt_eff + c_CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf    <= c_RESET_BUF;
      r_cnt    <= '0;
      r_mode_q <= 2'b00;
      r_step_q <= 1'b0;
    end else begin
      r_buf    <= w_buf_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mode_q <= bus.mode;
      r_step_q <= bus.step;
    end
  end

  assign bus.char_out = r_buf;
  assign bus.tick     = w_tick;

  generate
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_hex
      assign bus.hex_out[7*gi +: 7] = f_seg(r_buf[3*gi +: 3]);
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_hello_scroller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hello_scroller : directed scoreboard bench for hello_scroller (N=8,TD=4) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_hello_scroller;
  localparam int N  = 8;
  localparam int TD = 4;

  localparam logic [23:0] c_HELLO_FLAT = {3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
  localparam logic [23:0] c_LEFT3      = {3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0, 3'd1, 3'd2};
  localparam logic [23:0] c_LEFT1      = {3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0};
  localparam logic [23:0] c_LEFT2      = {3'd2, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd0, 3'd1};
  localparam logic [23:0] c_ALL_O      = {8{3'd3}};

  typedef struct {
    logic [23:0] chr;
    logic [55:0] hex;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  int   n_fail;
  exp_t sb[$];

  logic [2:0] mb [N];
  int         m_cnt;
  logic [1:0] m_mode_q;
  logic       m_step_q;

  hello_scroller_if #(.N_DIGITS(N)) bus ();

  hello_scroller #(.N_DIGITS(N), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Patterns written a..g left to right, then flipped so bit 0 is segment a.
  function automatic logic [6:0] seg_of(input logic [2:0] c);
    logic [6:0] ag;
    logic [6:0] r;
    case (c)
      3'd0:    ag = 7'b1001000;
      3'd1:    ag = 7'b0110000;
      3'd2:    ag = 7'b1110001;
      3'd3:    ag = 7'b0000001;
      default: ag = 7'b1111111;
    endcase
    for (int b = 0; b < 7; b++) r[b] = ag[6-b];
    return r;
  endfunction

  function automatic logic [23:0] pack_chr();
    logic [23:0] r;
    for (int i = 0; i < N; i++) r[3*i +: 3] = mb[i];
    return r;
  endfunction

  function automatic logic [55:0] pack_hex();
    logic [55:0] r;
    for (int i = 0; i < N; i++) r[7*i +: 7] = seg_of(mb[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mb[i] = c_HELLO_FLAT[3*i +: 3];
    m_cnt    = 0;
    m_mode_q = 2'b00;
    m_step_q = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs; returns the observed tick.
  task automatic cyc(input string tag, output logic t_obs);
    exp_t       e;
    logic [2:0] nb [N];
    bit         auto_m;
    bit         tk;
    bit         rise;
    int         eff;
    #2;
    t_obs  = bus.tick;
    auto_m = (bus.mode == 2'b01) || (bus.mode == 2'b10);
    eff    = (bus.mode != m_mode_q) ? 0 : m_cnt;
    tk     = auto_m && (eff == TD - 1);
    chk({tag, ".tick"}, 64'(bus.tick), 64'(tk));
    rise   = bus.step && !m_step_q;
    if (bus.load) begin
      for (int i = 0; i < N; i++) mb[i] = bus.load_data[3*i +: 3];
    end else if ((bus.mode == 2'b01 && tk) || (bus.mode == 2'b11 && rise)) begin
      for (int i = 0; i < N; i++) nb[i] = mb[(i + N - 1) % N];
      mb = nb;
    end else if (bus.mode == 2'b10 && tk) begin
      for (int i = 0; i < N; i++) nb[i] = mb[(i + 1) % N];
      mb = nb;
    end
    m_cnt    = bus.load ? 0 : ((auto_m && !tk) ? eff + 1 : 0);
    m_mode_q = bus.mode;
    m_step_q = bus.step;
    e.chr = pack_chr();
    e.hex = pack_hex();
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".char"}, 64'(bus.char_out), 64'(e.chr));
    chk({tag, ".hex"},  64'(bus.hex_out),  64'(e.hex));
  endtask

  initial begin
    logic t;
    int   nt;
    n_total = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0;
    bus.load = 1'b0; bus.load_data = '0; bus.mode = 2'b00; bus.step = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_char", 64'(bus.char_out), 64'(c_HELLO_FLAT));
    chk("rst_hex7", 64'(bus.hex_out[55:49]), 64'(seg_of(3'd0)));
    chk("rst_tick", 64'(bus.tick), 64'(0));
    rst_n = 1'b1;

    for (int k = 1; k <= 20; k++) begin
      cyc("hold", t);
      chk("hold_tick", 64'(t), 64'(0));
    end
    chk("hold_char", 64'(bus.char_out), 64'(c_HELLO_FLAT));

    bus.mode = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      cyc("left", t);
      chk("left_tickpos", 64'(t), 64'(k % 4 == 0));
    end
    chk("left3_char", 64'(bus.char_out), 64'(c_LEFT3));

    cyc("pre_arst", t);
    cyc("pre_arst", t);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_char", 64'(bus.char_out), 64'(c_HELLO_FLAT));
    chk("arst_hex7", 64'(bus.hex_out[55:49]), 64'(seg_of(3'd0)));
    chk("arst_tick", 64'(bus.tick), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 4; k++) begin
      cyc("post_arst", t);
      chk("post_arst_tickpos", 64'(t), 64'(k == 4));
    end

    rst_n = 1'b0;
    bus.mode = 2'b10;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    nt = 0;
    for (int k = 1; k <= 32; k++) begin
      cyc("right", t);
      if (t) nt++;
      if (k == 4) begin
        chk("right1_slot7", 64'(bus.char_out[23:21]), 64'(4));
        chk("right1_slot6", 64'(bus.char_out[20:18]), 64'(0));
      end
    end
    chk("right_ticks", 64'(nt), 64'(8));
    chk("right_wrap", 64'(bus.char_out), 64'(c_HELLO_FLAT));

    bus.mode = 2'b11;
    bus.step = 1'b0;
    cyc("man_idle", t);
    bus.step = 1'b1;
    cyc("man_hi", t);
    chk("man_first", 64'(bus.char_out), 64'(c_LEFT1));
    repeat (4) cyc("man_hi", t);
    chk("man_held", 64'(bus.char_out), 64'(c_LEFT1));
    bus.step = 1'b0;
    repeat (2) cyc("man_lo", t);
    bus.step = 1'b1;
    repeat (2) cyc("man_hi2", t);
    bus.step = 1'b0;
    cyc("man_lo2", t);
    chk("man_two", 64'(bus.char_out), 64'(c_LEFT2));
    chk("man_slot7", 64'(bus.char_out[23:21]), 64'(2));

    bus.mode = 2'b01;
    repeat (3) cyc("ld_pre", t);
    bus.load = 1'b1;
    bus.load_data = c_ALL_O;
    cyc("ld", t);
    chk("ld_tick", 64'(t), 64'(1));
    bus.load = 1'b0;
    bus.load_data = '0;
    chk("ld_char", 64'(bus.char_out), 64'(c_ALL_O));
    for (int k = 1; k <= 4; k++) begin
      cyc("ld_post", t);
      chk("ld_post_tickpos", 64'(t), 64'(k == 4));
    end
    chk("ld_post_char", 64'(bus.char_out), 64'(c_ALL_O));
    chk("sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
